instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter and instruction-address width.
REQ-002 SHALL have parameter EXEC_TIMEOUT, default 15, maximum cycles spent waiting for exec_done.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port sys_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin or restart execution.
REQ-006 SHALL have port imem_req  output  1  instruction fetch request.
REQ-007 SHALL have port imem_addr  output  PC_W  fetch address, equal to pc.
REQ-008 SHALL have port imem_rdata  input  32  fetched instruction.
REQ-009 SHALL have port imem_valid  input  1  imem_rdata valid.
REQ-010 SHALL have port ir_out  output  32  instruction register driven to the datapath IR.
REQ-011 SHALL have port ir_load  output  1  one-cycle pulse when ir_out changes.
REQ-012 SHALL have port exec_start  output  1  one-cycle pulse to datapath to execute ir_out.
REQ-013 SHALL have port exec_done  input  1  datapath completed instruction.
REQ-014 SHALL have port pc  output  PC_W  program counter.
REQ-015 SHALL have ports busy, halted, fault  output  1 each  status flags.

Function
REQ-016 SHALL decode the IR fields as oper_type=IR[31:27], rdst=IR[26:22], rsrc1=IR[21:17], imm_mode=IR[16], rsrc2=IR[15:11], isrc=IR[15:0].
REQ-017 SHALL implement the states IDLE, FETCH, DECODE, EXEC, HALT and FAULT; busy=1 in FETCH, DECODE and EXEC only.
REQ-018 IDLE: start=1 SHALL move the block to FETCH on the next edge.
REQ-019 FETCH: imem_req=1 and imem_addr=pc; imem_req SHALL stay high until imem_valid is sampled high.
REQ-020 On imem_valid in FETCH: ir_out<=imem_rdata; ir_load=1 the following cycle; the block SHALL move to DECODE.
REQ-021 DECODE (one cycle): oper_type=5'd31 (HALT) SHALL move to HALT with pc unchanged.
REQ-022 DECODE: oper_type=5'd30 (JMP) SHALL load pc<=isrc[PC_W-1:0] and move to FETCH, with no exec_start.
REQ-023 DECODE: any other oper_type SHALL pulse exec_start for exactly one cycle and move to EXEC.
REQ-024 EXEC: exec_done=1 SHALL set pc<=pc+1 (modulo 2^PC_W, so all-ones wraps to 0) and move to FETCH.
REQ-025 EXEC timeout: the wait counter clears on entry to EXEC and counts cycles; EXEC_TIMEOUT cycles without exec_done SHALL move to FAULT with pc unchanged.
REQ-026 exec_done arriving in the same cycle the counter reaches EXEC_TIMEOUT SHALL count as completion, not as a fault.
REQ-027 imem_valid outside FETCH and exec_done outside EXEC SHALL be ignored.
REQ-028 HALT: halted=1; start=1 SHALL clear halted, set pc<=0 and move to FETCH.
REQ-029 FAULT: fault=1 is sticky; start SHALL be ignored; only sys_rst exits FAULT.
REQ-030 start asserted while busy=1 SHALL be ignored.
REQ-031 Minimum latency per non-jump instruction SHALL be: fetch cycle, valid cycle, DECODE cycle, exec_start cycle, then exec_done.

Reset
REQ-032 While sys_rst=1 at a clock edge, the block SHALL enter IDLE and clear pc, ir_out, imem_req, ir_load, exec_start, busy, halted, fault and the wait counter.
REQ-033 Reset mid-fetch or mid-exec SHALL drop imem_req and exec_start at that same edge, and no pc increment SHALL occur.

Configuration
REQ-034 With macro SEQ_SINGLE_STEP_EN defined, the block SHALL add input step (1 bit) and hold in DECODE until step=1 before issuing exec_start or taking a jump or halt.
REQ-035 Without SEQ_SINGLE_STEP_EN, the step port SHALL be absent and DECODE SHALL last exactly one cycle.

Verification
REQ-036 Reset then start; memory returns 0x10080004 (ADD, oper 2), exec_done 2 cycles after exec_start -> exactly one ir_load and one exec_start pulse, pc=1, next fetch at addr 1.
REQ-037 Word at addr 0 has oper_type=30 and isrc=5 -> pc=5, no exec_start, next imem_addr=5.
REQ-038 pc=255 (PC_W=8), executed instruction completes -> pc wraps to 0.
REQ-039 exec_done never asserted -> fault=1 exactly 15 cycles after entering EXEC; start then ignored; sys_rst clears fault and pc.
REQ-040 HALT word (0xF8000000) -> halted=1, busy=0; start -> halted=0 and fetch at addr 0.
REQ-041 sys_rst asserted while imem_req=1 -> imem_req=0 at the next edge; a later imem_valid is ignored, ir_out=0.

Source files
------------

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Purpose:
//   Fetch / decode / execute control sequencer. It fetches a 32-bit instruction
//   from instruction memory at pc, latches it into the instruction register and
//   decodes the operation type. HALT (31) parks the block and JMP (30) reloads
//   pc. Every other operation is handed to the datapath through an exec_start
//   pulse. A bounded wait on exec_done moves the block to a sticky FAULT state
//   if the datapath never answers.
//
// Parameters:
//   PC_W          program-counter / instruction-address width
//   EXEC_TIMEOUT  maximum number of EXEC cycles spent waiting for exec_done
//
// Ports:
//   clk         in   single clock; all state changes on its rising edge
//   sys_rst     in   synchronous active-high reset
//   start       in   begin execution (IDLE) or restart from address 0 (HALT)
//   imem_req    out  fetch request, high for the whole FETCH state
//   imem_addr   out  fetch address (equal to pc)
//   imem_rdata  in   fetched instruction word
//   imem_valid  in   imem_rdata valid; sampled only in FETCH
//   ir_out      out  instruction register driven to the datapath
//   ir_load     out  one-cycle pulse in the cycle after ir_out changes
//   exec_start  out  one-cycle pulse telling the datapath to execute ir_out
//   exec_done   in   datapath finished; sampled only in EXEC
//   step        in   single-step release (SEQ_SINGLE_STEP_EN builds only)
//   pc          out  program counter
//   busy        out  high in FETCH, DECODE and EXEC
//   halted      out  high in HALT
//   fault       out  high in FAULT; sticky until sys_rst
//
// Configuration:
//   SEQ_SINGLE_STEP_EN  when defined, adds input 'step'. DECODE then holds
//                       until step=1 before it dispatches, jumps or halts.
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int PC_W         = 8,
  parameter int EXEC_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            sys_rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [31:0]     ir_out,
  output logic            ir_load,
  output logic            exec_start,
  input  logic            exec_done,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            fault
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  localparam logic [4:0] OP_JMP  = 5'd30;
  localparam logic [4:0] OP_HALT = 5'd31;

  localparam int              CNT_W    = $clog2(EXEC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_TIMEOUT - 1);

  // Instruction word layout. rsrc2 shares bits [15:11] with isrc. The
  // datapath selects between them with imm_mode, so only isrc is named here.
  typedef struct packed {
    logic [4:0]  oper_type;
    logic [4:0]  rdst;
    logic [4:0]  rsrc1;
    logic        imm_mode;
    logic [15:0] isrc;
  } ir_t;

  logic [2:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  ir_t              ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ir_load_q, ir_load_d;
  logic             exec_start_q, exec_start_d;
  logic             decode_go;

`ifdef SEQ_SINGLE_STEP_EN
  assign decode_go = step;
`else
  assign decode_go = 1'b1;
`endif

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    cnt_d        = cnt_q;
    ir_load_d    = 1'b0;
    exec_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_valid) begin
          ir_d      = ir_t'(imem_rdata);
          ir_load_d = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (decode_go) begin
          if (ir_q.oper_type == OP_HALT) begin
            state_d = S_HALT;
          end else if (ir_q.oper_type == OP_JMP) begin
            pc_d    = PC_W'(ir_q.isrc);
            state_d = S_FETCH;
          end else begin
            // exec_start is registered, so it is high in the first EXEC cycle.
            exec_start_d = 1'b1;
            cnt_d        = '0;
            state_d      = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        // Completion takes priority, so a done in the last allowed cycle
        // still counts as success.
        if (exec_done) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FAULT: ;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      ir_q         <= '0;
      cnt_q        <= '0;
      ir_load_q    <= 1'b0;
      exec_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      cnt_q        <= cnt_d;
      ir_load_q    <= ir_load_d;
      exec_start_q <= exec_start_d;
    end
  end

  // Status outputs decode straight from the state register. A reset edge
  // therefore drops imem_req, busy, halted and fault at that same edge.
  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ir_out     = ir_q;
  assign ir_load    = ir_load_q;
  assign exec_start = exec_start_q;
  assign busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                      (state_q == S_EXEC);
  assign halted     = (state_q == S_HALT);
  assign fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed self-checking bench for instr_sequencer with default parameters
// (PC_W=8, EXEC_TIMEOUT=15) and SEQ_SINGLE_STEP_EN undefined. Inputs change
// 1 ns after each rising edge, and outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam logic [31:0] W_ADD  = 32'h1008_0004;
  localparam logic [31:0] W_HALT = 32'hF800_0000;
  localparam logic [31:0] W_JMP  = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        sys_rst, start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] ir_out;
  logic        ir_load, exec_start, exec_done;
  logic [7:0]  pc;
  logic        busy, halted, fault;

  int n_vec = 0;
  int n_err = 0;
  int n_ir_load = 0;
  int n_exec_start = 0;
  int base_ld, base_es;

  instr_sequencer #(.PC_W(8), .EXEC_TIMEOUT(15)) dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .ir_out     (ir_out),
    .ir_load    (ir_load),
    .exec_start (exec_start),
    .exec_done  (exec_done),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Pulse counters: each high cycle is seen once, at the edge that ends it.
  always @(posedge clk) begin
    if (ir_load)    n_ir_load    = n_ir_load + 1;
    if (exec_start) n_exec_start = n_exec_start + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a fetch request, then returns the word with
  // imem_valid for one cycle. On return the DUT is in DECODE.
  task automatic fetch_word(input logic [31:0] w);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check("fetch_req_seen", imem_req, 1);
    imem_rdata = w;
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1; start = 1'b0; imem_rdata = '0; imem_valid = 1'b0;
    exec_done = 1'b0;
    tick();
    do_reset();

    // Reset state
    check("rst_pc", pc, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    check("rst_ir_out", ir_out, 0);
    check("rst_ir_load", ir_load, 0);
    check("rst_exec_start", exec_start, 0);

    // ADD at address 0, exec_done two cycles after exec_start
    base_ld = n_ir_load; base_es = n_exec_start;
    start = 1'b1; tick(); start = 1'b0;
    check("add_fetch_req", imem_req, 1);
    check("add_fetch_addr", imem_addr, 0);
    check("add_fetch_busy", busy, 1);
    tick();
    check("add_req_held", imem_req, 1);
    imem_rdata = W_ADD; imem_valid = 1'b1; tick(); imem_valid = 1'b0; imem_rdata = '0;
    check("add_ir_load", ir_load, 1);
    check("add_ir_out", ir_out, W_ADD);
    check("add_no_es_in_decode", exec_start, 0);
    check("add_req_dropped", imem_req, 0);
    tick();
    check("add_exec_start", exec_start, 1);
    check("add_ir_load_low", ir_load, 0);
    tick();
    check("add_es_one_cycle", exec_start, 0);
    tick();
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    check("add_pc", pc, 1);
    check("add_next_addr", imem_addr, 1);
    check("add_next_req", imem_req, 1);
    check("add_ir_load_cnt", n_ir_load - base_ld, 1);
    check("add_exec_start_cnt", n_exec_start - base_es, 1);

    // JMP from address 0 to 5
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    base_es = n_exec_start;
    fetch_word(W_JMP | 32'd5);
    tick();
    check("jmp_pc", pc, 5);
    check("jmp_addr", imem_addr, 5);
    check("jmp_req", imem_req, 1);
    check("jmp_no_exec_start", n_exec_start - base_es, 0);

    // pc wrap: jump to 255, execute, pc goes to 0
    fetch_word(W_JMP | 32'd255);
    tick();
    check("wrap_pc_255", pc, 255);
    fetch_word(W_ADD);
    tick();
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    check("wrap_pc_0", pc, 0);
    check("wrap_req", imem_req, 1);
    // exec_done while fetching must not move pc
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    check("done_outside_exec_pc", pc, 0);
    check("done_outside_exec_req", imem_req, 1);

    // HALT at address 7, then restart from 0
    fetch_word(W_JMP | 32'd7);
    tick();
    fetch_word(W_HALT);
    tick();
    check("halt_halted", halted, 1);
    check("halt_busy", busy, 0);
    check("halt_pc_kept", pc, 7);
    check("halt_no_req", imem_req, 0);
    start = 1'b1; tick(); start = 1'b0;
    check("restart_halted", halted, 0);
    check("restart_addr", imem_addr, 0);
    check("restart_req", imem_req, 1);

    // exec_done in the last allowed cycle counts as completion
    fetch_word(W_ADD);
    tick();                          // first EXEC cycle
    repeat (14) tick();              // fifteenth EXEC cycle
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    check("late_done_fault", fault, 0);
    check("late_done_pc", pc, 1);
    check("late_done_req", imem_req, 1);

    // Timeout at pc=3: fault exactly 15 cycles after entering EXEC
    fetch_word(W_JMP | 32'd3);
    tick();
    fetch_word(W_ADD);
    tick();
    check("to_busy_in_exec", busy, 1);
    start = 1'b1; tick(); start = 1'b0;  // ignored while busy
    repeat (13) tick();
    check("to_no_fault_at_14", fault, 0);
    tick();
    check("to_fault_at_15", fault, 1);
    check("to_pc_kept", pc, 3);
    check("to_busy", busy, 0);
    start = 1'b1; tick(); start = 1'b0;
    check("to_start_ignored_fault", fault, 1);
    check("to_start_ignored_req", imem_req, 0);
    do_reset();
    check("to_rst_fault", fault, 0);
    check("to_rst_pc", pc, 0);

    // Reset mid-fetch; a later imem_valid is ignored
    base_ld = n_ir_load;
    start = 1'b1; tick(); start = 1'b0;
    check("rf_req_before", imem_req, 1);
    do_reset();
    check("rf_req_dropped", imem_req, 0);
    imem_rdata = 32'hDEAD_BEEF; imem_valid = 1'b1; tick(); imem_valid = 1'b0; imem_rdata = '0;
    tick();
    check("rf_ir_out", ir_out, 0);
    check("rf_no_ir_load", n_ir_load - base_ld, 0);
    check("rf_busy", busy, 0);

    // Reset mid-exec together with exec_done: no pc increment
    start = 1'b1; tick(); start = 1'b0;
    fetch_word(W_ADD);
    tick();
    check("re_exec_start", exec_start, 1);
    sys_rst = 1'b1; exec_done = 1'b1; tick(); sys_rst = 1'b0; exec_done = 1'b0;
    check("re_es_dropped", exec_start, 0);
    check("re_pc", pc, 0);
    check("re_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
